sccb_init_sequencer: RTL and testbench
======================================

Name: sccb_init_sequencer

Overview:
- Drives the CoreSCCB master through a camera register-initialisation table held in an external synchronous ROM (e.g. OV2640 bring-up).
- Fetches {sub_addr, data} entries and issues one SCCB write per entry.
- Handles delay and end markers, inserts inter-transaction gaps, and watches for hung transfers.
- Sits between the system trigger/status logic and CoreSCCB. Owns the CoreSCCB start/RW/ip_addr/sub_addr/data_in inputs.

Parameters:
- DEV_ADDR, 8'h60, SCCB device write ID driven on sccb_ip_addr.
- ROM_AW, 8, ROM address width; table depth is 2^ROM_AW entries.
- GAP_CYCLES, 100, idle XCLK cycles between a done pulse and the next fetch.
- DELAY_CYCLES, 500000, XCLK cycles a delay entry waits (10 ms at 50 MHz).
- TIMEOUT_CYCLES, 100000, maximum XCLK cycles in WAIT_DONE before error.

Ports:
- XCLK  in  1  system clock (50 MHz).
- RST  in  1  asynchronous, active-high reset.
- init_start  in  1  one-cycle pulse; begins the sequence from ROM address 0.
- rom_addr  out  ROM_AW  table read address.
- rom_data  in  16  table entry {sub_addr[15:8], data[7:0]}, valid 1 cycle after rom_addr.
- sccb_start  out  1  one-cycle start pulse to CoreSCCB.
- sccb_rw  out  1  always 0 (write).
- sccb_ip_addr  out  8  device ID, equals DEV_ADDR.
- sccb_sub_addr  out  8  register address.
- sccb_data  out  8  register data.
- sccb_done  in  1  one-cycle completion pulse from CoreSCCB.
- busy  out  1  high from accepted init_start until DONE or ERROR.
- init_done  out  1  sticky; sequence completed.
- init_error  out  1  sticky; timeout occurred.
- entry_cnt  out  ROM_AW+1  number of writes completed in the current run.

Behaviour:
Reset values:
- All outputs reset to 0 except sccb_ip_addr = DEV_ADDR.
- rom_addr = 0.
- FSM = IDLE; all counters = 0.

Entry decoding:
- 16'hFFFF is the end marker.
- 16'hFFF0 is the delay marker.
- Any other value is a write entry.

FSM:
- IDLE: on init_start → FETCH. Same cycle: clear init_done, init_error and entry_cnt; set rom_addr = 0; set busy = 1.
- FETCH: wait one cycle for ROM latency → DECODE.
- DECODE:
  - End marker → DONE.
  - Delay marker → DELAY; load counter with DELAY_CYCLES-1.
  - Write entry → ISSUE; latch sccb_sub_addr = rom_data[15:8] and sccb_data = rom_data[7:0].
- ISSUE: assert sccb_start for exactly one cycle; load timeout counter → WAIT_DONE. Sub_addr/data stay stable until the next DECODE.
- WAIT_DONE:
  - On sccb_done: entry_cnt += 1; load gap counter with GAP_CYCLES-1 → GAP.
  - If the timeout counter reaches 0 without done → ERROR.
- GAP and DELAY: count down to 0, then → ADVANCE.
- ADVANCE:
  - If rom_addr == 2^ROM_AW-1 → DONE. The table is full with no end marker; no wrap to 0.
  - Else rom_addr += 1 → FETCH.
- DONE: init_done = 1, busy = 0 → IDLE.
- ERROR: init_error = 1, busy = 0 → IDLE. rom_addr holds the failing entry's address for debug.

Latency and handshake rules:
- Write entry latency: init_start to first sccb_start is 4 cycles (IDLE→FETCH→DECODE→ISSUE).
- Delay entry: adds DELAY_CYCLES+1 cycles, then proceeds directly to ADVANCE (no gap).
- init_start while busy is ignored.
- sccb_done outside WAIT_DONE is ignored.
- sccb_done in the first WAIT_DONE cycle is accepted.
- sccb_done and timeout expiry in the same cycle: done wins.

Width rules:
- Counters are sized with $clog2 of the larger of DELAY_CYCLES and TIMEOUT_CYCLES.
- entry_cnt saturates at 2^ROM_AW.

Reset mid-operation:
- RST at any state returns to reset values immediately.
- sccb_start drops asynchronously.
- Stale sticky flags are cleared.

Test Plan:
- ROM = {0x12_80, 0x11_01, 0xFFFF}; pulse init_start → sccb_start pulses exactly twice with (sub,data) = (12,80) then (11,01), sccb_ip_addr = 0x60, rw = 0; init_done = 1; entry_cnt = 2; busy low after DONE.
- ROM = {0x12_80, 0xFFF0, 0x11_01, 0xFFFF}, DELAY_CYCLES = 20 → second sccb_start occurs ≥ 20 cycles after the first done; entry_cnt = 2.
- Bench withholds sccb_done, TIMEOUT_CYCLES = 50 → init_error = 1 after 50 cycles in WAIT_DONE; rom_addr = 0; busy = 0; init_done = 0; next init_start clears init_error.
- ROM_AW = 2, table with no end marker (4 write entries) → 4 writes issued, init_done = 1, rom_addr stays at 3 (no wrap).
- init_start re-pulsed during WAIT_DONE → ignored; sequence unchanged. RST asserted during GAP → all outputs return to reset values within the same cycle; a fresh run then completes normally.
- sccb_done injected while in GAP/IDLE → no entry_cnt change. done and timeout expiry in the same cycle → counts as success, no error.

Source files
------------

// File: rtl/sccb_init_sequencer.sv
// Walks a camera register-initialisation table in an external synchronous ROM and
// issues one CoreSCCB write per entry, honouring delay and end markers and timing out hung writes.
module sccb_init_sequencer #(
   parameter logic [7:0] DEV_ADDR       = 8'h60,
   parameter int         ROM_AW         = 8,
   parameter int         GAP_CYCLES     = 100,
   parameter int         DELAY_CYCLES   = 500000,
   parameter int         TIMEOUT_CYCLES = 100000
) (
   input  logic              XCLK,
   input  logic              RST,
   input  logic              init_start,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   output logic              sccb_start,
   output logic              sccb_rw,
   output logic [7:0]        sccb_ip_addr,
   output logic [7:0]        sccb_sub_addr,
   output logic [7:0]        sccb_data,
   input  logic              sccb_done,
   output logic              busy,
   output logic              init_done,
   output logic              init_error,
   output logic [ROM_AW:0]   entry_cnt
);

   localparam int MAX_DT  = (DELAY_CYCLES > TIMEOUT_CYCLES) ? DELAY_CYCLES : TIMEOUT_CYCLES;
   localparam int MAX_ALL = (MAX_DT > GAP_CYCLES) ? MAX_DT : GAP_CYCLES;
   localparam int CW      = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

   localparam logic [CW-1:0]     DELAY_LOAD   = CW'(DELAY_CYCLES - 1);
   localparam logic [CW-1:0]     TIMEOUT_LOAD = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0]     GAP_LOAD     = CW'(GAP_CYCLES - 1);
   localparam logic [ROM_AW-1:0] LAST_ADDR    = '1;
   localparam logic [ROM_AW:0]   CNT_MAX      = {1'b1, {ROM_AW{1'b0}}};

   localparam logic [15:0] END_MARK   = 16'hFFFF;
   localparam logic [15:0] DELAY_MARK = 16'hFFF0;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_DONE,
      S_GAP, S_DELAY, S_ADVANCE, S_DONE, S_ERROR
   } state_t;

   state_t            state_q, state_d;
   logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [7:0]        sub_addr_q, sub_addr_d;
   logic [7:0]        data_q, data_d;
   logic              start_q, start_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic [ROM_AW:0]   entry_cnt_q, entry_cnt_d;

   always_ff @(posedge XCLK or posedge RST) begin
      if (RST) begin
         state_q     <= S_IDLE;
         rom_addr_q  <= '0;
         cnt_q       <= '0;
         sub_addr_q  <= '0;
         data_q      <= '0;
         start_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         entry_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rom_addr_q  <= rom_addr_d;
         cnt_q       <= cnt_d;
         sub_addr_q  <= sub_addr_d;
         data_q      <= data_d;
         start_q     <= start_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         entry_cnt_q <= entry_cnt_d;
      end
   end

   // The start pulse is raised on the DECODE->ISSUE transition so it is high for the ISSUE cycle only.
   always_comb begin
      state_d     = state_q;
      rom_addr_d  = rom_addr_q;
      cnt_d       = cnt_q;
      sub_addr_d  = sub_addr_q;
      data_d      = data_q;
      start_d     = 1'b0;
      busy_d      = busy_q;
      done_d      = done_q;
      error_d     = error_q;
      entry_cnt_d = entry_cnt_q;

      unique case (state_q)
         S_IDLE: begin
            if (init_start) begin
               state_d     = S_FETCH;
               done_d      = 1'b0;
               error_d     = 1'b0;
               entry_cnt_d = '0;
               rom_addr_d  = '0;
               busy_d      = 1'b1;
            end
         end
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            if (rom_data == END_MARK) begin
               state_d = S_DONE;
            end else if (rom_data == DELAY_MARK) begin
               state_d = S_DELAY;
               cnt_d   = DELAY_LOAD;
            end else begin
               state_d    = S_ISSUE;
               sub_addr_d = rom_data[15:8];
               data_d     = rom_data[7:0];
               start_d    = 1'b1;
            end
         end
         S_ISSUE: begin
            cnt_d   = TIMEOUT_LOAD;
            state_d = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            // Done is tested first so a completion on the final timeout cycle still counts.
            if (sccb_done) begin
               if (entry_cnt_q != CNT_MAX) entry_cnt_d = entry_cnt_q + 1'b1;
               cnt_d   = GAP_LOAD;
               state_d = S_GAP;
            end else if (cnt_q == '0) begin
               state_d = S_ERROR;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_GAP, S_DELAY: begin
            if (cnt_q == '0) state_d = S_ADVANCE;
            else cnt_d = cnt_q - 1'b1;
         end
         S_ADVANCE: begin
            if (rom_addr_q == LAST_ADDR) begin
               state_d = S_DONE;
            end else begin
               rom_addr_d = rom_addr_q + 1'b1;
               state_d    = S_FETCH;
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         S_ERROR: begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign rom_addr      = rom_addr_q;
   assign sccb_start    = start_q;
   assign sccb_rw       = 1'b0;
   assign sccb_ip_addr  = DEV_ADDR;
   assign sccb_sub_addr = sub_addr_q;
   assign sccb_data     = data_q;
   assign busy          = busy_q;
   assign init_done     = done_q;
   assign init_error    = error_q;
   assign entry_cnt     = entry_cnt_q;

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Directed bench: ROM models and CoreSCCB done responders around two sequencer instances
// (16-entry table with short timings, and a 4-entry table with no end marker).
module tb_sccb_init_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Instance A: 16-entry table
   logic        initStartA;
   logic [3:0]  romAddrA;
   logic [15:0] romDataA;
   logic        startA, rwA, doneA, busyA, initDoneA, initErrA;
   logic [7:0]  ipA, subA, dataA;
   logic [4:0]  entryCntA;
   logic [15:0] memA [16];

   sccb_init_sequencer #(.DEV_ADDR(8'h60), .ROM_AW(4), .GAP_CYCLES(5),
                         .DELAY_CYCLES(20), .TIMEOUT_CYCLES(50)) dutA (
      .XCLK(clk), .RST(rst), .init_start(initStartA), .rom_addr(romAddrA), .rom_data(romDataA),
      .sccb_start(startA), .sccb_rw(rwA), .sccb_ip_addr(ipA), .sccb_sub_addr(subA),
      .sccb_data(dataA), .sccb_done(doneA), .busy(busyA), .init_done(initDoneA),
      .init_error(initErrA), .entry_cnt(entryCntA));

   always @(posedge clk) romDataA <= memA[romAddrA];

   // Instance B: 4-entry table
   logic        initStartB;
   logic [1:0]  romAddrB;
   logic [15:0] romDataB;
   logic        startB, rwB, doneB, busyB, initDoneB, initErrB;
   logic [7:0]  ipB, subB, dataB;
   logic [2:0]  entryCntB;
   logic [15:0] memB [4];

   sccb_init_sequencer #(.DEV_ADDR(8'h60), .ROM_AW(2), .GAP_CYCLES(5),
                         .DELAY_CYCLES(20), .TIMEOUT_CYCLES(50)) dutB (
      .XCLK(clk), .RST(rst), .init_start(initStartB), .rom_addr(romAddrB), .rom_data(romDataB),
      .sccb_start(startB), .sccb_rw(rwB), .sccb_ip_addr(ipB), .sccb_sub_addr(subB),
      .sccb_data(dataB), .sccb_done(doneB), .busy(busyB), .init_done(initDoneB),
      .init_error(initErrB), .entry_cnt(entryCntB));

   always @(posedge clk) romDataB <= memB[romAddrB];

   // Responder A: logs each start and answers after respLatency cycles when enabled.
   bit         respEnable = 1'b1;
   int         respLatency = 3;
   int         pendA = 0;
   logic       respDoneA = 1'b0, injDoneA = 1'b0;
   int         nStarts = 0, nDones = 0;
   logic [7:0] logSub [64];
   logic [7:0] logData [64];
   int         startCyc [64];
   int         doneCyc [64];
   assign doneA = respDoneA | injDoneA;

   always @(negedge clk) begin
      respDoneA = 1'b0;
      if (pendA > 0) begin
         pendA = pendA - 1;
         if (pendA == 0) begin
            respDoneA = 1'b1;
            if (nDones < 64) doneCyc[nDones] = cyc;
            nDones = nDones + 1;
         end
      end
      if (startA === 1'b1) begin
         if (nStarts < 64) begin
            logSub[nStarts]   = subA;
            logData[nStarts]  = dataA;
            startCyc[nStarts] = cyc;
         end
         nStarts = nStarts + 1;
         if (respEnable) pendA = respLatency;
      end
   end

   // Responder B: fixed two-cycle answer.
   int   pendB = 0, nStartsB = 0;
   logic respDoneB = 1'b0;
   assign doneB = respDoneB;

   always @(negedge clk) begin
      respDoneB = 1'b0;
      if (pendB > 0) begin
         pendB = pendB - 1;
         if (pendB == 0) respDoneB = 1'b1;
      end
      if (startB === 1'b1) begin
         nStartsB = nStartsB + 1;
         pendB = 2;
      end
   end

   int passCount = 0;
   int checkCount = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
   endtask

   task automatic loadRomA(input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3);
      for (int i = 0; i < 16; i++) memA[i] = 16'hFFFF;
      memA[0] = e0; memA[1] = e1; memA[2] = e2; memA[3] = e3;
   endtask

   // Pulses init_start on A and waits (bounded) for done or error, optionally
   // re-pulsing init_start during the first write or injecting a stray done in the first gap.
   task automatic applyStimulus(input bit repulse, input bit injGap, output bit finished,
                                output int finCyc, output logic errAfterPulse);
      int  baseS = nStarts;
      int  baseD = nDones;
      bit  didPulse = 1'b0;
      bit  didInj = 1'b0;
      finished = 1'b0;
      finCyc = 0;
      @(negedge clk) initStartA = 1'b1;
      @(negedge clk) initStartA = 1'b0;
      errAfterPulse = initErrA;
      for (int i = 0; i < 3000; i++) begin
         if (initDoneA || initErrA) begin
            finished = 1'b1;
            finCyc = cyc;
            break;
         end
         if (repulse && !didPulse && (nStarts - baseS) == 1) begin
            initStartA = 1'b1;
            @(negedge clk) initStartA = 1'b0;
            didPulse = 1'b1;
         end
         if (injGap && !didInj && (nDones - baseD) == 1) begin
            repeat (2) @(negedge clk);
            injDoneA = 1'b1;
            @(negedge clk) injDoneA = 1'b0;
            didInj = 1'b1;
         end
         @(negedge clk);
      end
      checkOutput("runFinished", {31'd0, finished}, 32'd1);
   endtask

   initial begin
      bit   fin;
      int   fc, baseS, baseD;
      logic eap;

      rst = 1'b1;
      initStartA = 1'b0;
      initStartB = 1'b0;
      loadRomA(16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF);
      memB[0] = 16'h0101; memB[1] = 16'h0202; memB[2] = 16'h0303; memB[3] = 16'h0404;
      #1;
      checkOutput("rstStart", {31'd0, startA}, 32'd0);
      checkOutput("rstRw", {31'd0, rwA}, 32'd0);
      checkOutput("rstIpAddr", {24'd0, ipA}, 32'h60);
      checkOutput("rstBusy", {31'd0, busyA}, 32'd0);
      checkOutput("rstDone", {31'd0, initDoneA}, 32'd0);
      checkOutput("rstError", {31'd0, initErrA}, 32'd0);
      checkOutput("rstEntryCnt", {27'd0, entryCntA}, 32'd0);
      checkOutput("rstRomAddr", {28'd0, romAddrA}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] two-write table, init_start re-pulsed while waiting for done");
      baseS = nStarts;
      applyStimulus(1'b1, 1'b0, fin, fc, eap);
      checkOutput("basicStarts", nStarts - baseS, 32'd2);
      checkOutput("basicSub0", {24'd0, logSub[baseS]}, 32'h12);
      checkOutput("basicData0", {24'd0, logData[baseS]}, 32'h80);
      checkOutput("basicSub1", {24'd0, logSub[baseS+1]}, 32'h11);
      checkOutput("basicData1", {24'd0, logData[baseS+1]}, 32'h01);
      checkOutput("basicIpAddr", {24'd0, ipA}, 32'h60);
      checkOutput("basicRw", {31'd0, rwA}, 32'd0);
      checkOutput("basicDone", {31'd0, initDoneA}, 32'd1);
      checkOutput("basicError", {31'd0, initErrA}, 32'd0);
      checkOutput("basicEntryCnt", {27'd0, entryCntA}, 32'd2);
      checkOutput("basicBusy", {31'd0, busyA}, 32'd0);

      $display("[TB] stray done while idle");
      @(negedge clk) injDoneA = 1'b1;
      @(negedge clk) injDoneA = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("idleDoneEntryCnt", {27'd0, entryCntA}, 32'd2);

      $display("[TB] delay entry between two writes");
      loadRomA(16'h1280, 16'hFFF0, 16'h1101, 16'hFFFF);
      baseS = nStarts;
      baseD = nDones;
      applyStimulus(1'b0, 1'b0, fin, fc, eap);
      checkOutput("delayStarts", nStarts - baseS, 32'd2);
      checkOutput("delayGapOk", {31'd0, (startCyc[baseS+1] - doneCyc[baseD]) >= 20}, 32'd1);
      checkOutput("delayEntryCnt", {27'd0, entryCntA}, 32'd2);
      checkOutput("delaySub1", {24'd0, logSub[baseS+1]}, 32'h11);

      $display("[TB] withheld done leads to timeout");
      loadRomA(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      respEnable = 1'b0;
      baseS = nStarts;
      applyStimulus(1'b0, 1'b0, fin, fc, eap);
      checkOutput("toError", {31'd0, initErrA}, 32'd1);
      checkOutput("toDone", {31'd0, initDoneA}, 32'd0);
      checkOutput("toBusy", {31'd0, busyA}, 32'd0);
      checkOutput("toRomAddr", {28'd0, romAddrA}, 32'd0);
      checkOutput("toEntryCnt", {27'd0, entryCntA}, 32'd0);
      checkOutput("toLatency", fc - startCyc[baseS], 32'd52);
      respEnable = 1'b1;
      applyStimulus(1'b0, 1'b0, fin, fc, eap);
      checkOutput("reErrCleared", {31'd0, eap}, 32'd0);
      checkOutput("reDone", {31'd0, initDoneA}, 32'd1);
      checkOutput("reEntryCnt", {27'd0, entryCntA}, 32'd1);

      $display("[TB] done on the final timeout cycle and on the first wait cycle");
      respLatency = 50;
      applyStimulus(1'b0, 1'b0, fin, fc, eap);
      checkOutput("tieError", {31'd0, initErrA}, 32'd0);
      checkOutput("tieDone", {31'd0, initDoneA}, 32'd1);
      checkOutput("tieEntryCnt", {27'd0, entryCntA}, 32'd1);
      respLatency = 1;
      applyStimulus(1'b0, 1'b0, fin, fc, eap);
      checkOutput("firstCycDone", {31'd0, initDoneA}, 32'd1);
      checkOutput("firstCycEntryCnt", {27'd0, entryCntA}, 32'd1);
      respLatency = 3;

      $display("[TB] stray done during gap");
      loadRomA(16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF);
      applyStimulus(1'b0, 1'b1, fin, fc, eap);
      checkOutput("gapDoneEntryCnt", {27'd0, entryCntA}, 32'd2);
      checkOutput("gapDoneFlag", {31'd0, initDoneA}, 32'd1);

      $display("[TB] reset asserted during gap");
      baseD = nDones;
      @(negedge clk) initStartA = 1'b1;
      @(negedge clk) initStartA = 1'b0;
      for (int i = 0; i < 200 && (nDones - baseD) < 1; i++) @(negedge clk);
      checkOutput("midDoneSeen", nDones - baseD, 32'd1);
      repeat (2) @(negedge clk);
      checkOutput("midBusyBefore", {31'd0, busyA}, 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("midRstStart", {31'd0, startA}, 32'd0);
      checkOutput("midRstBusy", {31'd0, busyA}, 32'd0);
      checkOutput("midRstEntryCnt", {27'd0, entryCntA}, 32'd0);
      checkOutput("midRstRomAddr", {28'd0, romAddrA}, 32'd0);
      checkOutput("midRstIpAddr", {24'd0, ipA}, 32'h60);
      checkOutput("midRstSub", {24'd0, subA}, 32'd0);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      baseS = nStarts;
      applyStimulus(1'b0, 1'b0, fin, fc, eap);
      checkOutput("postRstStarts", nStarts - baseS, 32'd2);
      checkOutput("postRstDone", {31'd0, initDoneA}, 32'd1);
      checkOutput("postRstEntryCnt", {27'd0, entryCntA}, 32'd2);

      $display("[TB] full 4-entry table with no end marker");
      @(negedge clk) initStartB = 1'b1;
      @(negedge clk) initStartB = 1'b0;
      for (int i = 0; i < 1000 && !initDoneB && !initErrB; i++) @(negedge clk);
      checkOutput("fullStarts", nStartsB, 32'd4);
      checkOutput("fullDone", {31'd0, initDoneB}, 32'd1);
      checkOutput("fullError", {31'd0, initErrB}, 32'd0);
      checkOutput("fullRomAddr", {30'd0, romAddrB}, 32'd3);
      checkOutput("fullEntryCnt", {29'd0, entryCntB}, 32'd4);
      checkOutput("fullBusy", {31'd0, busyB}, 32'd0);
      checkOutput("fullLastSub", {24'd0, subB}, 32'h04);
      checkOutput("fullIpRw", {23'd0, ipB, rwB}, {23'd0, 8'h60, 1'b0});
      repeat (3) @(negedge clk);
      checkOutput("fullRomAddrHold", {30'd0, romAddrB}, 32'd3);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
